// File: rtl/sm3_cf_arbiter.sv
// Round-robin arbiter sharing one sm3_CF compression core between NREQ requesters.
// It latches the winner's operands, sequences the core start/end handshake and runs a hang watchdog.
module sm3_cf_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*256-1:0]   req_iv,
  input  logic [NREQ*512-1:0]   req_blk,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [255:0]          hash_out,
  output logic                  err,
  output logic                  cf_start,
  output logic [255:0]          cf_iv,
  output logic [511:0]          cf_blk,
  input  logic [255:0]          cf_hash,
  input  logic                  cf_end
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic [15:0]         wd_cnt;

  logic [2*NREQ-1:0]   req_rot;
  logic                found;
  logic [PW-1:0]       offset;
  logic [PW:0]         sum;
  logic [PW:0]         sum_wrap;
  logic [PW-1:0]       win;
  logic [NREQ-1:0]     win_onehot;
  logic [PW-1:0]       next_ptr;

  // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit
  // is then the offset of the winner from rr_ptr.
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    found   = 1'b0;
    offset  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = PW'(k);
      end
    end
    sum      = {1'b0, rr_ptr} + {1'b0, offset};
    sum_wrap = sum - (PW+1)'(NREQ);
    win      = (sum >= (PW+1)'(NREQ)) ? sum_wrap[PW-1:0] : sum[PW-1:0];
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
    next_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      wd_cnt   <= '0;
      gnt      <= '0;
      done     <= '0;
      hash_out <= '0;
      err      <= 1'b0;
      cf_start <= 1'b0;
      cf_iv    <= '0;
      cf_blk   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= win_onehot;
            owner    <= win;
            cf_iv    <= req_iv[256*win +: 256];
            cf_blk   <= req_blk[512*win +: 512];
            cf_start <= 1'b1;
            wd_cnt   <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          wd_cnt <= wd_cnt + 16'd1;
          // A completion in the same cycle as the watchdog limit counts as success.
          if (cf_end) begin
            hash_out <= cf_hash;
            done     <= gnt;
            cf_start <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= DRAIN;
          end else if (wd_cnt == WD_LIMIT) begin
            err      <= 1'b1;
            done     <= gnt;
            cf_start <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          // Hold here until the core drops cf_end so a stale level cannot finish the next job.
          if (!cf_end) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_cf_arbiter.sv
// Directed bench for sm3_cf_arbiter with a behavioural sm3_CF core of configurable latency.
module tb_sm3_cf_arbiter;

  localparam logic [255:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] ABC_HASH =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [1023:0] req_iv;
  logic [2047:0] req_blk;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic [255:0]  hash_out;
  logic          err;
  logic          cf_start;
  logic [255:0]  cf_iv;
  logic [511:0]  cf_blk;
  logic [255:0]  cf_hash;
  logic          cf_end;

  int checks   = 0;
  int failures = 0;
  int inv_bad  = 0;
  int core_cnt = 0;
  int lat      = 10;
  logic core_en = 1'b1;
  logic stuck   = 1'b0;
  logic mon_en  = 1'b0;
  logic prev_start = 1'b0;
  logic [3:0] prev_done = '0;

  logic [255:0] iv_t [4];
  logic [511:0] blk_t [4];

  always #5 clk = ~clk;

  sm3_cf_arbiter #(.NREQ(4), .TIMEOUT(80)) dut (
    .clk(clk), .reset(reset), .req(req), .req_iv(req_iv), .req_blk(req_blk),
    .gnt(gnt), .done(done), .hash_out(hash_out), .err(err),
    .cf_start(cf_start), .cf_iv(cf_iv), .cf_blk(cf_blk),
    .cf_hash(cf_hash), .cf_end(cf_end)
  );

  // Core stand-in: returns the real "abc" digest for that block, a simple mix otherwise.
  function automatic logic [255:0] core_fn(input logic [255:0] iv, input logic [511:0] blk);
    if (iv == SM3_IV && blk == ABC_BLK) return ABC_HASH;
    return {iv[254:0], iv[255]} ^ blk[511:256] ^ blk[255:0];
  endfunction

  assign cf_hash = core_fn(cf_iv, cf_blk);
  assign cf_end  = stuck || (core_en && cf_start && core_cnt == lat - 1);

  always_ff @(posedge clk) core_cnt <= cf_start ? core_cnt + 1 : 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!$onehot0(done) || (done & ~gnt) != 4'b0 || !$onehot0(gnt)) inv_bad++;
      if (done != 4'b0 && prev_done != 4'b0) inv_bad++;
      if (cf_start && !prev_start && cf_end) inv_bad++;
    end
    prev_start = cf_start;
    prev_done  = done;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [255:0] iv, input logic [511:0] blk);
    req_iv[256*i +: 256]  = iv;
    req_blk[512*i +: 512] = blk;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 4'b0 && n < max);
    check(tag, |done, 1'b1);
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int bad;
    logic [255:0] cur;
    logic [255:0] ref_h;
    logic [255:0] h4;
    logic [511:0] cblk [5];

    reset = 1'b1; req = '0; req_iv = '0; req_blk = '0;
    for (int i = 0; i < 4; i++) begin
      iv_t[i]  = {8{32'h11111111 * 32'(i + 1)}};
      blk_t[i] = {16{32'hA0000000 + 32'(i)}};
    end
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_gnt", gnt, 4'b0);
    check("rst_done", done, 4'b0);
    check("rst_hash", hash_out, 256'b0);
    check("rst_err", err, 1'b0);
    check("rst_start", cf_start, 1'b0);
    check("rst_iv", cf_iv, 256'b0);
    check("rst_blk", cf_blk, 512'b0);
    reset = 1'b0;

    // Single "abc" request on requester 2, 64-cycle core.
    lat = 64;
    set_ops(2, SM3_IV, ABC_BLK);
    req = 4'b0100;
    @(negedge clk);
    check("abc_gnt", gnt, 4'b0100);
    check("abc_start", cf_start, 1'b1);
    check("abc_cf_iv", cf_iv, SM3_IV);
    check("abc_cf_blk", cf_blk, ABC_BLK);
    wait_done("abc_seen", 200, n);
    check("abc_lat", n, 64);
    check("abc_done", done, 4'b0100);
    check("abc_hash", hash_out, ABC_HASH);
    check("abc_err", err, 1'b0);
    req = '0;
    @(negedge clk);
    check("abc_done_1cyc", done, 4'b0);
    check("abc_gnt_rel", gnt, 4'b0);

    // All four requesters active from reset: order 0,1,2,3,0 with 12 cycles per job.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lat = 10;
    for (int i = 0; i < 4; i++) set_ops(i, iv_t[i], blk_t[i]);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done("rr_seen", 100, n);
      if (j > 0) check("rr_gap", n, 12);
      check("rr_done", done, oh(j % 4));
      check("rr_hash", hash_out, core_fn(iv_t[j % 4], blk_t[j % 4]));
    end
    req = '0;
    @(negedge clk);

    // Requester 1 chains five blocks, feeding each result back as the next IV.
    cur = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    ref_h = cur;
    for (int k = 0; k < 5; k++) begin
      cblk[k] = {16{32'h5a5a0000 + 32'(k)}};
      ref_h = core_fn(ref_h, cblk[k]);
    end
    set_ops(1, cur, cblk[0]);
    req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      wait_done("chain_seen", 100, n);
      check("chain_done", done, 4'b0010);
      if (k < 4) set_ops(1, hash_out, cblk[k + 1]);
      else req = '0;
    end
    check("chain_hash", hash_out, ref_h);
    @(negedge clk);

    // cf_end arriving on the watchdog's last cycle completes normally.
    lat = 80;
    set_ops(2, iv_t[2], blk_t[2]);
    req = 4'b0100;
    wait_done("edge_seen", 200, n);
    check("edge_lat", n, 81);
    check("edge_err", err, 1'b0);
    h4 = core_fn(iv_t[2], blk_t[2]);
    check("edge_hash", hash_out, h4);
    req = '0;
    @(negedge clk);

    // Core that never finishes: watchdog aborts after TIMEOUT cycles.
    core_en = 1'b0;
    set_ops(3, iv_t[3], blk_t[3]);
    req = 4'b1000;
    wait_done("wd_seen", 200, n);
    check("wd_lat", n, 81);
    check("wd_done", done, 4'b1000);
    check("wd_err", err, 1'b1);
    check("wd_start", cf_start, 1'b0);
    check("wd_hash_kept", hash_out, h4);
    req = '0;
    @(negedge clk);
    core_en = 1'b1;
    lat = 5;
    set_ops(0, iv_t[0], blk_t[0]);
    req = 4'b0001;
    wait_done("wd_next_seen", 100, n);
    check("wd_next_done", done, 4'b0001);
    check("wd_next_hash", hash_out, core_fn(iv_t[0], blk_t[0]));
    check("wd_err_sticky", err, 1'b1);
    req = '0;
    @(negedge clk);

    // Reset in the middle of RUN, then a late cf_end that must be ignored.
    lat = 7;
    req = 4'b0001;
    @(negedge clk);
    check("mid_gnt", gnt, 4'b0001);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_gnt", gnt, 4'b0);
    check("mid_rst_start", cf_start, 1'b0);
    check("mid_rst_done", done, 4'b0);
    check("mid_rst_hash", hash_out, 256'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_iv", cf_iv, 256'b0);
    reset = 1'b0;
    stuck = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != 4'b0 || cf_start || gnt != 4'b0) bad++;
    end
    check("late_end_absorbed", bad, 0);
    stuck = 1'b0;
    req = 4'b0001;
    wait_done("mid_next_seen", 50, n);
    check("mid_next_lat", n, 8);
    check("mid_next_hash", hash_out, core_fn(iv_t[0], blk_t[0]));

    // cf_end stuck high after completion keeps the arbiter in DRAIN.
    req = 4'b0100;
    stuck = 1'b1;
    lat = 3;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (cf_start || gnt != 4'b0001 || done != 4'b0) bad++;
    end
    check("stuck_drain", bad, 0);
    stuck = 1'b0;
    @(negedge clk);
    check("stuck_idle_gnt", gnt, 4'b0);
    check("stuck_idle_start", cf_start, 1'b0);
    @(negedge clk);
    check("stuck_regrant", gnt, 4'b0100);
    check("stuck_restart", cf_start, 1'b1);
    wait_done("stuck_seen", 50, n);
    check("stuck_hash", hash_out, h4);
    req = '0;
    repeat (3) @(negedge clk);

    check("invariants", inv_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
